muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_sign_fix.sv | 46 ++++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, widths and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int ITERS  = 32;
  localparam int CNT_W  = $clog2(ITERS);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed(input op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand sign/magnitude split on entry and sign correction of the raw
// unsigned result on exit; purely combinational.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] mag_a,
  output logic [DATA_W-1:0] mag_b,
  output logic              neg_a,
  output logic              neg_b,
  input  op_e               fix_op,
  input  logic              fix_neg_a,
  input  logic              fix_neg_b,
  input  logic [2*DATA_W-1:0] raw,
  output logic [DATA_W-1:0] fix_hi,
  output logic [DATA_W-1:0] fix_lo
);

  always_comb begin
    neg_a = is_signed(op) & rs_data[DATA_W-1];
    neg_b = is_signed(op) & rt_data[DATA_W-1];
    mag_a = neg_a ? (~rs_data + 1'b1) : rs_data;
    mag_b = neg_b ? (~rt_data + 1'b1) : rt_data;
  end

  // Unsigned ops latch both sign flags as zero, so no op check is needed here.
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;

  always_comb begin
    prod = (fix_neg_a ^ fix_neg_b) ? (~raw + 1'b1) : raw;
    quot = (fix_neg_a ^ fix_neg_b) ? (~raw[DATA_W-1:0] + 1'b1) : raw[DATA_W-1:0];
    rem  = fix_neg_a ? (~raw[2*DATA_W-1:DATA_W] + 1'b1) : raw[2*DATA_W-1:DATA_W];
    if (is_div(fix_op)) begin
      fix_hi = rem;
      fix_lo = quot;
    end else begin
      fix_hi = prod[2*DATA_W-1:DATA_W];
      fix_lo = prod[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide with HI/LO registers, one bit per
// cycle, cancellable, with MTHI/MTLO write bypass while idle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              W_start,
  input  logic [1:0]        W_op,
  input  logic [DATA_W-1:0] W_rs_data,
  input  logic [DATA_W-1:0] W_rt_data,
  input  logic              W_hilo_w_ena,
  input  logic              W_hilo_w_sel,
  input  logic [DATA_W-1:0] W_hilo_w_data,
  input  logic              W_cancel,
  output logic              R_busy,
  output logic              R_done,
  output logic [DATA_W-1:0] R_hi,
  output logic [DATA_W-1:0] R_lo
);

  state_e              state, state_nx;
  op_e                 op_in, op_q;
  logic                neg_a_q, neg_b_q, div0_q, done_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc, acc_step;
  logic [DATA_W-1:0]   opb, hi_q, lo_q;

  logic [DATA_W-1:0]   mag_a, mag_b, fix_hi, fix_lo;
  logic                neg_a, neg_b;
  logic                start_ok, div0;

  assign op_in    = op_e'(W_op);
  assign start_ok = (state == ST_IDLE) && W_start && !W_cancel;
  assign div0     = is_div(op_in) && (W_rt_data == '0);

  muldiv_sign_fix u_sign_fix (
    .op        (op_in),
    .rs_data   (W_rs_data),
    .rt_data   (W_rt_data),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .fix_op    (op_q),
    .fix_neg_a (neg_a_q),
    .fix_neg_b (neg_b_q),
    .raw       (acc),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_ok) state_nx = div0 ? ST_FIX : ST_CALC;
      ST_CALC: begin
        if (W_cancel)                       state_nx = ST_IDLE;
        else if (cnt == CNT_W'(ITERS - 1))  state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [DATA_W:0] mul_sum, div_rem, div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
    div_rem  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff = div_rem - {1'b0, opb};
    div_ge   = !div_diff[DATA_W];
    if (is_div(op_q))
      acc_step = {(div_ge ? div_diff[DATA_W-1:0] : div_rem[DATA_W-1:0]),
                  acc[DATA_W-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_MULT;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (W_hilo_w_ena) begin
            if (W_hilo_w_sel) hi_q <= W_hilo_w_data;
            else              lo_q <= W_hilo_w_data;
          end
          if (start_ok) begin
            op_q    <= op_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            div0_q  <= div0;
            cnt     <= '0;
            if (div0) begin
              acc <= {W_rs_data, {DATA_W{1'b1}}};
            end else if (is_div(op_in)) begin
              acc <= {{DATA_W{1'b0}}, mag_a};
              opb <= mag_b;
            end else begin
              acc <= {{DATA_W{1'b0}}, mag_b};
              opb <= mag_a;
            end
          end
        end
        ST_CALC: begin
          if (!W_cancel) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          // Divide-by-zero results bypass sign correction entirely.
          if (!W_cancel) begin
            hi_q   <= div0_q ? acc[2*DATA_W-1:DATA_W] : fix_hi;
            lo_q   <= div0_q ? acc[DATA_W-1:0]        : fix_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign R_busy = (state != ST_IDLE);
  assign R_done = done_q;
  assign R_hi   = ((state == ST_IDLE) && W_hilo_w_ena &&  W_hilo_w_sel) ? W_hilo_w_data : hi_q;
  assign R_lo   = ((state == ST_IDLE) && W_hilo_w_ena && !W_hilo_w_sel) ? W_hilo_w_data : lo_q;

endmodule
